// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state type and width helpers for the SRAM port arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } arb_state_t;

    function automatic int idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    // The strobe counter runs from WAIT_CYCLES-1 down to 0
    function automatic int wait_cnt_width(input int wait_cycles);
        return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - combinational fixed-priority / round-robin winner select
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PRIO_MODE = 0,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic [IDX_W-1:0]     o_grant,
    output logic                 o_valid
);

    int w_base;

    // Fixed priority is round-robin with the pointer pinned at the last port.
    // Candidates are visited farthest-first so the nearest hit after the base wins.
    always_comb begin
        w_base  = (PRIO_MODE == 0) ? NUM_PORTS - 1 : int'(i_last);
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (i_req[j] && (j == (w_base + k) % NUM_PORTS)) begin
                    o_grant = IDX_W'(j);
                    o_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - multi-port arbiter and strobe sequencer for an asynchronous SRAM
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int NUM_PORTS   = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int PRIO_MODE   = 0,
    localparam int BE_W       = DATA_W / 8,
    localparam int IDX_W      = idx_width(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_ce,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*BE_W-1:0]   req_sel,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_ack,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        busy,
    output logic [IDX_W-1:0]            grant_idx,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [BE_W-1:0]             ram_be_n,
    output logic                        ram_ce_n,
    output logic                        ram_oe_n,
    output logic                        ram_we_n,
    output logic [DATA_W-1:0]           ram_data_o,
    output logic                        ram_data_oe,
    input  logic [DATA_W-1:0]           ram_data_i
);

    localparam int CNT_W = wait_cnt_width(WAIT_CYCLES);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [IDX_W-1:0]  r_grant;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  w_grant;
    logic              w_valid;
    logic              r_we;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              w_last_strobe;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [BE_W-1:0]   w_sel_be;
    logic [DATA_W-1:0] w_sel_wdata;

    sram_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PRIO_MODE (PRIO_MODE),
        .IDX_W     (IDX_W)
    ) u_arb (
        .i_req   (req_ce),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_be    = req_sel[i*BE_W +: BE_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_last_strobe = (r_wait_cnt == '0);
    assign busy          = (r_state != ST_IDLE);
    assign grant_idx     = r_grant;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_state_next = ST_SETUP;
            ST_SETUP:  w_state_next = ST_STROBE;
            ST_STROBE: if (w_last_strobe) w_state_next = ST_HOLD;
            ST_HOLD:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // SRAM pins are registered one cycle ahead of the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant     <= '0;
            r_last      <= IDX_W'(NUM_PORTS - 1);
            r_we        <= 1'b0;
            r_wait_cnt  <= '0;
            req_ack     <= '0;
            req_rdata   <= '0;
            ram_addr    <= '0;
            ram_be_n    <= '1;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_data_o  <= '0;
            ram_data_oe <= 1'b0;
        end else begin
            req_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant     <= w_grant;
                        r_we        <= w_sel_we;
                        ram_ce_n    <= 1'b0;
                        ram_addr    <= w_sel_addr;
                        ram_be_n    <= ~w_sel_be;
                        ram_data_o  <= w_sel_wdata;
                        ram_data_oe <= w_sel_we;
                    end
                end
                ST_SETUP: begin
                    r_wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                    ram_oe_n   <= r_we;
                    ram_we_n   <= ~r_we;
                end
                ST_STROBE: begin
                    if (w_last_strobe) begin
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        if (!r_we) req_rdata <= ram_data_i;
                        req_ack  <= NUM_PORTS'(1) << r_grant;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    ram_ce_n    <= 1'b1;
                    ram_be_n    <= '1;
                    ram_data_oe <= 1'b0;
                    r_last      <= r_grant;
                end
                default: ;
            endcase
        end
    end

endmodule
